apb_bcd_slave_gen: RTL and testbench
====================================

Name: apb_bcd_slave_gen

Overview:
Parametrised APB slave carrying a sequential BCD arithmetic engine; it is the next generation of the existing APB master/slave pair. Exposes operand/control/result registers at word addresses and runs digit-serial BCD add/subtract with a sign-magnitude result. Adds configurable wait states, PSLVERR and busy/done status. Sits behind the existing APB master on PCLK.

Parameters:
ADDR_W, 32, address bus width
DATA_W, 32, data bus width (>= 4*DIGITS+3)
DIGITS, 7, BCD digits per operand/result
WAIT, 1, wait states inserted per access (0 = zero-wait)

Ports:
PCLK  in  1  clock, rising edge
PRESET  in  1  reset, synchronous, active-high
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  1 = write, 0 = read
PRWADDR  in  ADDR_W  byte address
PRWDATA  in  DATA_W  write data
PRDATA1  out  DATA_W  read data, valid in completion cycle
PREADY  out  1  transfer complete
PSLVERR  out  1  error, valid in completion cycle
busy  out  1  engine running

Behaviour:
- Reset (sync, PRESET=1 at edge): PREADY=0, PSLVERR=0, PRDATA1=0, busy=0; A, B, CTRL, RESULT, status = 0; FSM->IDLE; wait counter=0. Reset mid-operation aborts the engine; no partial result kept.
- APB: setup = PSEL&!PENABLE; access = PSEL&PENABLE. Wait counter increments each access cycle while < WAIT; PREADY=1 when counter==WAIT, else 0. Transfer completes on an edge with PSEL&PENABLE&PREADY; counter clears on completion or PSEL=0. PREADY=0 outside access phase.
- Map (PRWADDR[3:2]): 0x0 A RW; 0x4 B RW; 0x8 CTRL; 0xC RESULT RO.
- CTRL write: [1:0] op (00 clear, 01 BCD add, 10 BCD sub, 11 binary add), [2] start (self-clearing, reads 0). CTRL read: [1:0] op, [29] err, [30] busy, [31] done.
- RESULT: [4*DIGITS-1:0] digits, [30] carry/overflow, [31] sign (1 = negative). Op 11: full DATA_W binary sum, wraps mod 2^DATA_W.
- PSLVERR=1 (write ignored, PRDATA1=0) on: PRWADDR[1:0]!=0, PRWADDR[ADDR_W-1:4]!=0, write to 0xC, write to A/B/CTRL while busy. Reads while busy are legal.
- Engine FSM: IDLE -> (start) CHECK -> RUN -> [FIX] -> DONE -> IDLE.
  - start clears done/err. CHECK (1 cycle): any A/B nibble in [4*DIGITS-1:0] > 9 for op 01/10 -> err=1, RESULT=0, go DONE. Op 00 -> RESULT=0, DONE. Op 11 -> RESULT=A+B, DONE.
  - RUN: one digit per cycle, LSD first, DIGITS cycles. Add: s=a+b+c; if s>9 then s+=6, c=1. Sub: a+(9-b)+c with c0=1.
  - Sub, final carry 1: sign=0, go DONE. Final carry 0: go FIX, DIGITS cycles computing ten's complement of the result (9-r+c, c0=1), sign=1.
  - Add, final carry: RESULT[30]=1, digits wrap.
  - DONE (1 cycle): done=1, busy=0. busy=1 in CHECK/RUN/FIX.
- Latency start-write completion -> done: add 1+DIGITS+1; sub positive same; sub negative 1+2*DIGITS+1; op 00/11/err 2.
- start while busy: PSLVERR, ignored.

Test Plan:
- Reset held 2 cycles with PSEL=1 -> PREADY=0, PSLVERR=0, PRDATA1=0, busy=0; read 0xC after reset -> 0x0000_0000.
- A=0x0000_0007, B=0x0000_0007, CTRL=0x5 -> busy for 8 cycles, CTRL read 0x8000_0001, RESULT=0x0000_0014.
- A=0x0000_0012, B=0x0000_0057, CTRL=0x6 -> RESULT=0x8000_0045 after 16 cycles; A=0x57, B=0x12 -> 0x0000_0045.
- A=0x0999_9999, B=0x0000_0001, add -> RESULT=0x4000_0000; A=0x0000_000A, add -> CTRL read bit29=1, RESULT=0.
- Access 0x10, 0x2, write 0xC, write A while busy -> PSLVERR=1 each, registers unchanged.
- WAIT=2: PREADY low first 2 access cycles, high on 3rd; WAIT=0: PREADY high on first access cycle.

Source files
------------

// File: rtl/apb_bcd_slave_gen.sv
// apb_bcd_slave_gen: APB slave exposing A/B/CTRL/RESULT registers and a
// digit-serial BCD add/subtract engine with sign-magnitude result.
module apb_bcd_slave_gen #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DIGITS = 7,
    parameter int WAIT   = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PRWADDR,
    input  logic [DATA_W-1:0] PRWDATA,
    output logic [DATA_W-1:0] PRDATA1,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              busy
);
    localparam int NW = 4 * DIGITS;
    localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] WAIT_C = CW'(WAIT);
    localparam logic [DW-1:0] LAST_C = DW'(DIGITS - 1);

    typedef enum logic [2:0] {IDLE, CHECK, RUN, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [NW-1:0]     wrk_q, wrk_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [1:0]        op_q, op_d;
    logic              c_q, c_d, err_q, err_d, done_q, done_d;
    logic              access, xfer, slv_err, wr, start, bad, cout, last;
    logic [1:0]        idx;
    logic [3:0]        an, bn, rn, x, y, dnib;
    logic [4:0]        sum;
    logic [DATA_W-1:0] ctrl_rd, rdata;

    assign busy    = state_q inside {CHECK, RUN, FIX};
    assign access  = PSEL & PENABLE;
    assign PREADY  = ~PRESET & access & (wcnt_q == WAIT_C);
    assign xfer    = PREADY;
    assign idx     = PRWADDR[3:2];
    assign slv_err = (|PRWADDR[1:0]) | (|PRWADDR[ADDR_W-1:4]) | (PWRITE & ((idx == 2'd3) | busy));
    assign wr      = xfer & PWRITE & ~slv_err;
    assign start   = wr & (idx == 2'd2) & PRWDATA[2];
    assign PSLVERR = xfer & slv_err;
    assign wcnt_d  = (~PSEL | xfer) ? '0 : (access && wcnt_q < WAIT_C) ? wcnt_q + 1'b1 : wcnt_q;
    assign rdata   = (idx == 2'd0) ? a_q : (idx == 2'd1) ? b_q : (idx == 2'd2) ? ctrl_rd : res_q;
    assign PRDATA1 = (xfer & ~PWRITE & ~slv_err) ? rdata : '0;

    always_comb begin
        ctrl_rd     = '0;
        ctrl_rd[1:0] = op_q;
        ctrl_rd[29] = err_q;
        ctrl_rd[30] = busy;
        ctrl_rd[31] = done_q;
    end

    // One BCD digit step; FIX reuses the adder for the ten's complement (9-r+c).
    always_comb begin
        an  = '0;
        bn  = '0;
        rn  = '0;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q == DW'(i)) begin
                an = a_q[4*i +: 4];
                bn = b_q[4*i +: 4];
                rn = wrk_q[4*i +: 4];
            end
            bad |= (a_q[4*i +: 4] > 4'd9) | (b_q[4*i +: 4] > 4'd9);
        end
        x    = (state_q == FIX) ? 4'd9 - rn : an;
        y    = (state_q == FIX) ? 4'd0 : (op_q == 2'd2) ? 4'd9 - bn : bn;
        sum  = {1'b0, x} + {1'b0, y} + {4'b0, c_q};
        cout = sum > 5'd9;
        dnib = cout ? sum[3:0] + 4'd6 : sum[3:0];
        last = dig_q == LAST_C;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        wrk_d   = wrk_q;
        dig_d   = dig_q;
        op_d    = op_q;
        c_d     = c_q;
        err_d   = err_q;
        done_d  = done_q;
        case (state_q)
            CHECK: begin
                dig_d = '0;
                c_d   = op_q == 2'd2;
                wrk_d = '0;
                if (op_q == 2'd0 || op_q == 2'd3) begin
                    res_d   = (op_q == 2'd3) ? a_q + b_q : '0;
                    state_d = DONE;
                end else if (bad) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN, FIX: begin
                for (int i = 0; i < DIGITS; i++)
                    if (dig_q == DW'(i)) wrk_d[4*i +: 4] = dnib;
                c_d   = cout;
                dig_d = last ? '0 : dig_q + 1'b1;
                if (last) begin
                    c_d     = 1'b1;
                    state_d = (state_q == RUN && op_q == 2'd2 && !cout) ? FIX : DONE;
                    if (state_d == DONE) begin
                        res_d     = DATA_W'(wrk_d);
                        res_d[31] = state_q == FIX;
                        res_d[30] = (op_q == 2'd1) & cout;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase
        if (wr) begin
            a_d  = (idx == 2'd0) ? PRWDATA : a_q;
            b_d  = (idx == 2'd1) ? PRWDATA : b_q;
            op_d = (idx == 2'd2) ? PRWDATA[1:0] : op_q;
        end
        if (start) begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = CHECK;
        end
        if (state_d == DONE) done_d = 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            wrk_q   <= '0;
            dig_q   <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            wrk_q   <= wrk_d;
            dig_q   <= dig_d;
            op_q    <= op_d;
            c_q     <= c_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_apb_bcd_slave_gen.sv
// tb_apb_bcd_slave_gen: self-checking bench for the APB BCD slave; expected
// results come from an integer-arithmetic model queued at stimulus time.
module tb_apb_bcd_slave_gen;
    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PRWADDR, PRWDATA;
    logic [31:0] rd1, rd2, rd0;
    logic        rdy1, rdy2, rdy0, err1, err2, err0, busy1, busy2, busy0;
    int          tests = 0, fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] d, exp_v;
    logic        e;
    int          nb;

    always #5 PCLK = ~PCLK;

    apb_bcd_slave_gen #(.ADDR_W(32), .DATA_W(32), .DIGITS(7), .WAIT(1)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRDATA1(rd1), .PREADY(rdy1),
        .PSLVERR(err1), .busy(busy1));
    apb_bcd_slave_gen #(.ADDR_W(32), .DATA_W(32), .DIGITS(7), .WAIT(2)) dut_w2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRDATA1(rd2), .PREADY(rdy2),
        .PSLVERR(err2), .busy(busy2));
    apb_bcd_slave_gen #(.ADDR_W(32), .DATA_W(32), .DIGITS(7), .WAIT(0)) dut_w0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRDATA1(rd0), .PREADY(rdy0),
        .PSLVERR(err0), .busy(busy0));

    function automatic longint bcd2int(input logic [27:0] v);
        longint r = 0;
        for (int i = 6; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [27:0] int2bcd(input longint n);
        logic [27:0] r = '0;
        for (int i = 0; i < 7; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic bad_bcd(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 7; i++)
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        longint av, bv, s;
        if (op == 2'd0) return 32'h0;
        if (op == 2'd3) return a + b;
        if (bad_bcd(a, b)) return 32'h0;
        av = bcd2int(a[27:0]);
        bv = bcd2int(b[27:0]);
        if (op == 2'd1) begin
            s = av + bv;
            return {1'b0, s >= 10000000, 2'b00, int2bcd(s % 10000000)};
        end
        s = av - bv;
        return (s < 0) ? {4'b1000, int2bcd(-s)} : {4'b0000, int2bcd(s)};
    endfunction

    task automatic apb(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic serr);
        logic got = 1'b0;
        rdata = '0;
        serr  = 1'b0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PRWADDR = addr; PRWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge PCLK);
            if (rdy1) begin
                got   = 1'b1;
                rdata = rd1;
                serr  = err1;
            end
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL apb_ready addr=%h: PREADY stayed 0, required 1 within 16 cycles", addr);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, output int nbusy);
        logic [31:0] t;
        logic        te;
        apb(1'b1, 32'h0, a, t, te);
        apb(1'b1, 32'h4, b, t, te);
        exp_q.push_back(model(a, b, op));
        apb(1'b1, 32'h8, {29'b0, 1'b1, op}, t, te);
        nbusy = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge PCLK);
            if (!busy1) break;
            nbusy++;
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PRWADDR = '0; PRWDATA = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        tests += 5;
        if (rdy1 !== 1'b0) begin fails++; $display("FAIL reset_pready: got %b required 0", rdy1); end
        if (rdy0 !== 1'b0) begin fails++; $display("FAIL reset_pready_w0: got %b required 0", rdy0); end
        if (err1 !== 1'b0) begin fails++; $display("FAIL reset_pslverr: got %b required 0", err1); end
        if (rd1 !== 32'h0) begin fails++; $display("FAIL reset_prdata: got %h required 0", rd1); end
        if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy1); end
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        apb(1'b0, 32'hC, 32'h0, d, e);
        tests++;
        if (d !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL reset_result: got %h/%b required 00000000/0", d, e); end
        apb(1'b0, 32'h8, 32'h0, d, e);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h required 00000000", d); end
    endtask

    task automatic test_add();
        start_op(32'h7, 32'h7, 2'd1, nb);
        tests++;
        if (nb !== 8) begin fails++; $display("FAIL add_busy_cycles: got %0d required 8", nb); end
        apb(1'b0, 32'hC, 32'h0, d, e);
        exp_v = exp_q.pop_front();
        tests++;
        if (d !== exp_v || d !== 32'h14) begin fails++; $display("FAIL add_result: got %h required %h", d, exp_v); end
        apb(1'b0, 32'h8, 32'h0, d, e);
        tests++;
        if (d !== 32'h8000_0001) begin fails++; $display("FAIL add_ctrl: got %h required 80000001", d); end
    endtask

    task automatic test_sub();
        start_op(32'h12, 32'h57, 2'd2, nb);
        tests++;
        if (nb !== 15) begin fails++; $display("FAIL subneg_busy_cycles: got %0d required 15", nb); end
        apb(1'b0, 32'hC, 32'h0, d, e);
        exp_v = exp_q.pop_front();
        tests++;
        if (d !== exp_v) begin fails++; $display("FAIL subneg_result: got %h required %h", d, exp_v); end
        start_op(32'h57, 32'h12, 2'd2, nb);
        tests++;
        if (nb !== 8) begin fails++; $display("FAIL subpos_busy_cycles: got %0d required 8", nb); end
        apb(1'b0, 32'hC, 32'h0, d, e);
        exp_v = exp_q.pop_front();
        tests++;
        if (d !== exp_v) begin fails++; $display("FAIL subpos_result: got %h required %h", d, exp_v); end
        start_op(32'h0123_4567, 32'h0123_4567, 2'd2, nb);
        apb(1'b0, 32'hC, 32'h0, d, e);
        exp_v = exp_q.pop_front();
        tests++;
        if (d !== exp_v) begin fails++; $display("FAIL subzero_result: got %h required %h", d, exp_v); end
    endtask

    task automatic test_overflow();
        start_op(32'h0999_9999, 32'h1, 2'd1, nb);
        apb(1'b0, 32'hC, 32'h0, d, e);
        exp_v = exp_q.pop_front();
        tests++;
        if (d !== exp_v) begin fails++; $display("FAIL add_carry_result: got %h required %h", d, exp_v); end
        start_op(32'hA, 32'h1, 2'd1, nb);
        tests++;
        if (nb !== 1) begin fails++; $display("FAIL badbcd_busy_cycles: got %0d required 1", nb); end
        apb(1'b0, 32'hC, 32'h0, d, e);
        exp_v = exp_q.pop_front();
        tests++;
        if (d !== exp_v) begin fails++; $display("FAIL badbcd_result: got %h required %h", d, exp_v); end
        apb(1'b0, 32'h8, 32'h0, d, e);
        tests++;
        if (d !== 32'hA000_0001) begin fails++; $display("FAIL badbcd_ctrl: got %h required a0000001", d); end
    endtask

    task automatic test_binary();
        start_op(32'hFFFF_FFFF, 32'h2, 2'd3, nb);
        tests++;
        if (nb !== 1) begin fails++; $display("FAIL bin_busy_cycles: got %0d required 1", nb); end
        apb(1'b0, 32'hC, 32'h0, d, e);
        exp_v = exp_q.pop_front();
        tests++;
        if (d !== exp_v) begin fails++; $display("FAIL bin_result: got %h required %h", d, exp_v); end
        start_op(32'h5, 32'h5, 2'd0, nb);
        apb(1'b0, 32'hC, 32'h0, d, e);
        exp_v = exp_q.pop_front();
        tests++;
        if (d !== exp_v) begin fails++; $display("FAIL clear_result: got %h required %h", d, exp_v); end
        apb(1'b0, 32'h8, 32'h0, d, e);
        tests++;
        if (d !== 32'h8000_0000) begin fails++; $display("FAIL clear_ctrl: got %h required 80000000", d); end
    endtask

    task automatic test_errors();
        apb(1'b0, 32'h10, 32'h0, d, e);
        tests++;
        if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL err_addr_high: got %b/%h required 1/00000000", e, d); end
        apb(1'b0, 32'h2, 32'h0, d, e);
        tests++;
        if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL err_unaligned: got %b/%h required 1/00000000", e, d); end
        apb(1'b1, 32'hC, 32'h1234, d, e);
        tests++;
        if (e !== 1'b1) begin fails++; $display("FAIL err_write_result: got %b required 1", e); end
        apb(1'b0, 32'hC, 32'h0, d, e);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL err_result_kept: got %h required 00000000", d); end
        apb(1'b1, 32'h0, 32'h13, d, e);
        apb(1'b1, 32'h4, 32'h25, d, e);
        exp_q.push_back(model(32'h13, 32'h25, 2'd2));
        apb(1'b1, 32'h8, 32'h6, d, e);
        apb(1'b1, 32'h0, 32'h99, d, e);
        tests++;
        if (e !== 1'b1) begin fails++; $display("FAIL err_write_busy_a: got %b required 1", e); end
        apb(1'b0, 32'h4, 32'h0, d, e);
        tests++;
        if (e !== 1'b0 || d !== 32'h25) begin fails++; $display("FAIL read_busy_b: got %b/%h required 0/00000025", e, d); end
        apb(1'b1, 32'h8, 32'h5, d, e);
        tests++;
        if (e !== 1'b1) begin fails++; $display("FAIL err_start_busy: got %b required 1", e); end
        nb = 0;
        while (busy1 && nb < 64) begin @(negedge PCLK); nb++; end
        tests++;
        if (busy1 !== 1'b0) begin fails++; $display("FAIL busy_timeout: got busy %b required 0 within 64 cycles", busy1); end
        apb(1'b0, 32'h0, 32'h0, d, e);
        tests++;
        if (d !== 32'h13) begin fails++; $display("FAIL err_a_kept: got %h required 00000013", d); end
        apb(1'b0, 32'hC, 32'h0, d, e);
        exp_v = exp_q.pop_front();
        tests++;
        if (d !== exp_v) begin fails++; $display("FAIL err_busy_result: got %h required %h", d, exp_v); end
        apb(1'b0, 32'h8, 32'h0, d, e);
        tests++;
        if (d !== 32'h8000_0002) begin fails++; $display("FAIL err_ctrl_kept: got %h required 80000002", d); end
    endtask

    task automatic test_reset_abort();
        apb(1'b1, 32'h0, 32'h12, d, e);
        apb(1'b1, 32'h4, 32'h57, d, e);
        apb(1'b1, 32'h8, 32'h6, d, e);
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        tests++;
        if (busy1 !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b required 0", busy1); end
        apb(1'b0, 32'hC, 32'h0, d, e);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL abort_result: got %h required 00000000", d); end
        apb(1'b0, 32'h8, 32'h0, d, e);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL abort_ctrl: got %h required 00000000", d); end
    endtask

    task automatic test_wait();
        logic [2:0] e1, e2, e0;
        e1 = 3'b010;
        e2 = 3'b100;
        e0 = 3'b111;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PRWADDR = 32'h0;
        @(negedge PCLK);
        tests++;
        if ({rdy2, rdy1, rdy0} !== 3'b000) begin fails++; $display("FAIL wait_setup_pready: got %b required 000", {rdy2, rdy1, rdy0}); end
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            tests += 3;
            if (rdy1 !== e1[c]) begin fails++; $display("FAIL wait1_pready_c%0d: got %b required %b", c, rdy1, e1[c]); end
            if (rdy2 !== e2[c]) begin fails++; $display("FAIL wait2_pready_c%0d: got %b required %b", c, rdy2, e2[c]); end
            if (rdy0 !== e0[c]) begin fails++; $display("FAIL wait0_pready_c%0d: got %b required %b", c, rdy0, e0[c]); end
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_binary();
        test_errors();
        test_reset_abort();
        test_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
